sha_msg_schedule: RTL and testbench

- Upstream feeder for `sha_round`: accepts one 512-bit message block and emits the SHA-256 message schedule words Wt, t = 0..ROUNDS-1, one per accepted transfer.
- Also emits the round index t, so the round controller can look up Kt and drive `sha_round` (in, Kt, Wt -> out).
- Uses a 16-word sliding window, so W16..W63 are generated on the fly without storing all 64 words.

---
 rtl/sha_msg_schedule_pkg.sv | 32 +++
 rtl/sha_small_sigma.sv | 19 +
 rtl/sha_msg_schedule.sv | 73 +++++++
 tb/tb_sha_msg_schedule.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sha_msg_schedule_pkg.sv
// rtl/sha_msg_schedule_pkg.sv - shared SHA-256 widths, constants and helpers
package sha_msg_schedule_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int WIN     = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [WORD_W-1:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants; consumed by the round controller, not by the schedule.
  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha_small_sigma.sv
// rtl/sha_small_sigma.sv - SHA-256 small sigma; SEL=0 gives s0, SEL=1 gives s1
module sha_small_sigma
  import sha_msg_schedule_pkg::*;
#(
  parameter int SEL = 0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  generate
    if (SEL == 0) begin : g_s0
      assign y = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    end else begin : g_s1
      assign y = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    end
  endgenerate

endmodule

// File: rtl/sha_msg_schedule.sv
// rtl/sha_msg_schedule.sv - SHA-256 message schedule, 16-word sliding window
module sha_msg_schedule
  import sha_msg_schedule_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               start_ready,
  input  logic [BLOCK_W-1:0] block,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WORD_W-1:0]  Wt,
  output logic [5:0]         t,
  output logic               done
);

  logic [0:0]        state;
  logic [WORD_W-1:0] win [WIN];
  logic [5:0]        cnt;
  logic              done_q;
  logic [WORD_W-1:0] sig0, sig1, w_next;
  logic              xfer, last;

  sha_small_sigma #(.SEL(0)) u_s0 (.x(win[1]),  .y(sig0));
  sha_small_sigma #(.SEL(1)) u_s1 (.x(win[14]), .y(sig1));

  // Window head is W[t]; the new tail is W[t+16], built from W[t+14], W[t+9], W[t+1], W[t].
  assign w_next = sig1 + win[9] + sig0 + win[0];
  assign xfer   = (state == ST_RUN) && w_ready;
  assign last   = (cnt == 6'(ROUNDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      for (int j = 0; j < WIN; j++) win[j] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int j = 0; j < WIN; j++) win[j] <= block[BLOCK_W-1-WORD_W*j -: WORD_W];
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        default: begin
          if (xfer) begin
            for (int j = 0; j < WIN-1; j++) win[j] <= win[j+1];
            win[WIN-1] <= w_next;
            if (last) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
      endcase
    end
  end

  assign start_ready = (state == ST_IDLE);
  assign w_valid     = (state == ST_RUN);
  assign Wt          = win[0];
  assign t           = cnt;
  assign done        = done_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// tb/tb_sha_msg_schedule.sv - directed self-checking bench for sha_msg_schedule
module tb_sha_msg_schedule;

  logic         clk = 1'b0;
  logic         reset_n, start, w_ready;
  logic         start_ready, w_valid, done;
  logic [511:0] block;
  logic [31:0]  Wt;
  logic [5:0]   t;

  int checks = 0;
  int errors = 0;

  logic [511:0] abc_blk;
  logic [31:0]  gold [64];

  always #5 clk = ~clk;

  sha_msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ready(start_ready),
    .block(block), .w_valid(w_valid), .w_ready(w_ready),
    .Wt(Wt), .t(t), .done(done)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_gold();
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    for (int i = 0; i < 16; i++) gold[i] = abc_blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      gold[i] = m_s1(gold[i-2]) + gold[i-7] + m_s0(gold[i-15]) + gold[i-16];
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; w_ready = 1'b0; block = '0;
    repeat (2) @(negedge clk);
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid got %b want 0", w_valid); end
    checks++; if (Wt !== 32'h0) begin errors++; $display("FAIL reset_Wt got %h want 00000000", Wt); end
    checks++; if (t !== 6'd0) begin errors++; $display("FAIL reset_t got %0d want 0", t); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_abc();
    logic [31:0] hand;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL abc_ready got %b want 1", start_ready); end
    start = 1'b1; block = abc_blk; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++; if (w_valid !== 1'b1 || t !== 6'(i)) begin errors++; $display("FAIL abc_t valid=%b t=%0d want valid=1 t=%0d", w_valid, t, i); end
      checks++; if (Wt !== gold[i]) begin errors++; $display("FAIL abc_Wt t=%0d got %h want %h", i, Wt, gold[i]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abc_early_done t=%0d got %b want 0", i, done); end
      if (i == 0 || i == 15 || i >= 16 && i <= 18) begin
        case (i)
          0:  hand = 32'h61626380;
          15: hand = 32'h00000018;
          16: hand = 32'h61626380;
          17: hand = 32'h000f0000;
          default: hand = 32'h7da86405;
        endcase
        checks++; if (Wt !== hand) begin errors++; $display("FAIL abc_hand t=%0d got %h want %h", i, Wt, hand); end
      end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abc_done got %b want 1", done); end
    checks++; if (start_ready !== 1'b1 || w_valid !== 1'b0) begin errors++; $display("FAIL abc_idle ready=%b valid=%b want 1 0", start_ready, w_valid); end
    checks++; if (t !== 6'd0) begin errors++; $display("FAIL abc_t_clear got %0d want 0", t); end
    w_ready = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abc_done_pulse got %b want 0", done); end
  endtask

  task automatic test_stall();
    start = 1'b1; block = abc_blk; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 16) begin
        w_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++; if (Wt !== 32'h61626380 || t !== 6'd16 || w_valid !== 1'b1) begin
            errors++; $display("FAIL stall cyc=%0d Wt=%h t=%0d valid=%b want 61626380 16 1", s, Wt, t, w_valid);
          end
        end
        w_ready = 1'b1;
      end
      checks++; if (Wt !== gold[i] || t !== 6'(i)) begin errors++; $display("FAIL stall_seq t=%0d Wt=%h want t=%0d Wt=%h", t, Wt, i, gold[i]); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", done); end
    w_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    start = 1'b1; block = abc_blk; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++; if (Wt !== gold[i] || t !== 6'(i)) begin errors++; $display("FAIL ign_seq t=%0d Wt=%h want t=%0d Wt=%h", t, Wt, i, gold[i]); end
      start = (i == 10 || i == 63);
      block = (i == 10) ? ~abc_blk : '0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (done !== 1'b1 || w_valid !== 1'b0) begin errors++; $display("FAIL ign_final done=%b valid=%b want 1 0", done, w_valid); end
    w_ready = 1'b0;
    @(negedge clk);
    checks++; if (w_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL ign_no_reload valid=%b ready=%b want 0 1", w_valid, start_ready); end
  endtask

  task automatic test_reset_mid();
    bit seen_done = 1'b0;
    start = 1'b1; block = abc_blk; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) @(negedge clk);
    checks++; if (t !== 6'd30) begin errors++; $display("FAIL rmid_pre_t got %0d want 30", t); end
    reset_n = 1'b0;
    #1;
    checks++; if (w_valid !== 1'b0 || t !== 6'd0 || Wt !== 32'h0 || start_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_state valid=%b t=%0d Wt=%h ready=%b want 0 0 00000000 1", w_valid, t, Wt, start_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rmid_done got pulse want none"); end
    w_ready = 1'b0;
    test_load_abc();
  endtask

  task automatic test_back_to_back();
    int gap;
    start = 1'b1; block = abc_blk; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 64; i++) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
    start = 1'b1; block = '0;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) start = 1'b0;
      if (gap <= 64) begin
        checks++; if (w_valid !== 1'b1 || Wt !== 32'h0 || t !== 6'(gap - 1)) begin
          errors++; $display("FAIL b2b_word valid=%b t=%0d Wt=%h want 1 %0d 00000000", w_valid, t, Wt, gap - 1);
        end
      end
    end while (done !== 1'b1 && gap < 100);
    checks++; if (gap != 65) begin errors++; $display("FAIL b2b_gap got %0d want 65", gap); end
    w_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    build_gold();
    test_reset();
    test_load_abc();
    test_stall();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
